// File: rtl/mu0_pkg.sv
// Shared MU0 definitions: opcodes, control-state encoding, ALU function codes
// and the control-word bundle passed from the decoder to the controller.
package mu0_pkg;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_EXECUTE = 2'd1,
    ST_HALT    = 2'd2
  } state_t;

  localparam logic [3:0] OP_LDA = 4'd0;
  localparam logic [3:0] OP_STA = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd3;
  localparam logic [3:0] OP_JMP = 4'd4;
  localparam logic [3:0] OP_JGE = 4'd5;
  localparam logic [3:0] OP_JNE = 4'd6;
  localparam logic [3:0] OP_STP = 4'd7;

  localparam logic [1:0] ALU_Y   = 2'b00;
  localparam logic [1:0] ALU_ADD = 2'b01;
  localparam logic [1:0] ALU_INC = 2'b10;
  localparam logic [1:0] ALU_SUB = 2'b11;

  typedef struct packed {
    logic       x_sel;
    logic       y_sel;
    logic       addr_sel;
    logic       pc_en;
    logic       ir_en;
    logic       acc_en;
    logic [1:0] alu_fs;
    logic       mem_rq;
    logic       rnw;
    logic       halted;
  } ctrl_t;

endpackage

// File: rtl/mu0_decode.sv
// Combinational control decode: {state, opcode, N, Z} -> datapath control word.
// Everything not explicitly driven for a state/opcode stays at 0.
module mu0_decode
  import mu0_pkg::*;
(
  input  state_t     state,
  input  logic [3:0] f,
  input  logic       n,
  input  logic       z,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      ST_FETCH: begin
        ctrl.addr_sel = 1'b0;
        ctrl.mem_rq   = 1'b1;
        ctrl.rnw      = 1'b1;
        ctrl.ir_en    = 1'b1;
        ctrl.x_sel    = 1'b1;
        ctrl.alu_fs   = ALU_INC;
        ctrl.pc_en    = 1'b1;
      end
      ST_EXECUTE: begin
        case (f)
          OP_LDA: begin
            ctrl.addr_sel = 1'b1;
            ctrl.mem_rq   = 1'b1;
            ctrl.rnw      = 1'b1;
            ctrl.y_sel    = 1'b1;
            ctrl.alu_fs   = ALU_Y;
            ctrl.acc_en   = 1'b1;
          end
          OP_STA: begin
            ctrl.addr_sel = 1'b1;
            ctrl.mem_rq   = 1'b1;
            ctrl.rnw      = 1'b0;
          end
          OP_ADD, OP_SUB: begin
            ctrl.addr_sel = 1'b1;
            ctrl.mem_rq   = 1'b1;
            ctrl.rnw      = 1'b1;
            ctrl.x_sel    = 1'b0;
            ctrl.y_sel    = 1'b1;
            ctrl.acc_en   = 1'b1;
            ctrl.alu_fs   = (f == OP_ADD) ? ALU_ADD : ALU_SUB;
          end
          // Jumps load PC from IR[11:0] through the ALU pass-through
          OP_JMP: ctrl.pc_en = 1'b1;
          OP_JGE: ctrl.pc_en = ~n;
          OP_JNE: ctrl.pc_en = ~z;
          default: ;
        endcase
      end
      ST_HALT: ctrl.halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/mu0_control.sv
// MU0 control unit: FETCH/EXECUTE/HALT sequencer plus executed-instruction counter.
// Control outputs are forced quiet while Reset is held so no memory cycle starts.
module mu0_control
  import mu0_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic [3:0]  F,
  input  logic        N,
  input  logic        Z,
  output logic        X_sel,
  output logic        Y_sel,
  output logic        Addr_sel,
  output logic        PC_En,
  output logic        IR_En,
  output logic        Acc_En,
  output logic [1:0]  ALU_FS,
  output logic        MEMrq,
  output logic        RnW,
  output logic        Halted,
  output logic [15:0] InstCount
);

  state_t      state;
  state_t      state_nxt;
  logic [15:0] inst_count;
  ctrl_t       ctrl;
  ctrl_t       ctrl_out;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state <= ST_FETCH;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_FETCH:   state_nxt = ST_EXECUTE;
      ST_EXECUTE: state_nxt = (F == OP_STP) ? ST_HALT : ST_FETCH;
      ST_HALT:    state_nxt = ST_HALT;
      default:    state_nxt = ST_FETCH;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)                  inst_count <= 16'd0;
    else if (state == ST_EXECUTE) inst_count <= inst_count + 16'd1;
  end

  mu0_decode u_decode (
    .state (state),
    .f     (F),
    .n     (N),
    .z     (Z),
    .ctrl  (ctrl)
  );

  assign ctrl_out  = Reset ? ctrl : '0;

  assign X_sel     = ctrl_out.x_sel;
  assign Y_sel     = ctrl_out.y_sel;
  assign Addr_sel  = ctrl_out.addr_sel;
  assign PC_En     = ctrl_out.pc_en;
  assign IR_En     = ctrl_out.ir_en;
  assign Acc_En    = ctrl_out.acc_en;
  assign ALU_FS    = ctrl_out.alu_fs;
  assign MEMrq     = ctrl_out.mem_rq;
  assign RnW       = ctrl_out.rnw;
  assign Halted    = ctrl_out.halted;
  assign InstCount = inst_count;

endmodule

// File: tb/tb_mu0_control.sv
// Directed bench for mu0_control: opcode decode table, async reset abort,
// STP/HALT behaviour and InstCount wrap-around.
module tb_mu0_control;

  logic        Clk;
  logic        Reset;
  logic [3:0]  F;
  logic        N;
  logic        Z;
  logic        X_sel, Y_sel, Addr_sel, PC_En, IR_En, Acc_En, MEMrq, RnW, Halted;
  logic [1:0]  ALU_FS;
  logic [15:0] InstCount;
  logic [10:0] outs;

  int n_checks = 0;
  int n_pass   = 0;
  logic [15:0] exp_count;

  // {X_sel, Y_sel, Addr_sel, PC_En, IR_En, Acc_En, ALU_FS, MEMrq, RnW, Halted}
  localparam logic [10:0] V_FETCH = 11'b100_110_10_110;
  localparam logic [10:0] V_LDA   = 11'b011_001_00_110;
  localparam logic [10:0] V_STA   = 11'b001_000_00_100;
  localparam logic [10:0] V_ADD   = 11'b011_001_01_110;
  localparam logic [10:0] V_SUB   = 11'b011_001_11_110;
  localparam logic [10:0] V_JUMP  = 11'b000_100_00_000;
  localparam logic [10:0] V_QUIET = 11'b000_000_00_000;
  localparam logic [10:0] V_HALT  = 11'b000_000_00_001;

  typedef struct {
    string       name;
    logic [3:0]  f;
    logic        n;
    logic        z;
    logic [10:0] exp;
  } vec_t;

  vec_t vecs[12];

  mu0_control dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .F         (F),
    .N         (N),
    .Z         (Z),
    .X_sel     (X_sel),
    .Y_sel     (Y_sel),
    .Addr_sel  (Addr_sel),
    .PC_En     (PC_En),
    .IR_En     (IR_En),
    .Acc_En    (Acc_En),
    .ALU_FS    (ALU_FS),
    .MEMrq     (MEMrq),
    .RnW       (RnW),
    .Halted    (Halted),
    .InstCount (InstCount)
  );

  assign outs = {X_sel, Y_sel, Addr_sel, PC_En, IR_En, Acc_En, ALU_FS, MEMrq, RnW, Halted};

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    else
      n_pass++;
  endtask

  initial begin
    vecs[0]  = '{"lda",        4'd0,  1'b0, 1'b0, V_LDA};
    vecs[1]  = '{"sta",        4'd1,  1'b0, 1'b0, V_STA};
    vecs[2]  = '{"add",        4'd2,  1'b1, 1'b0, V_ADD};
    vecs[3]  = '{"sub",        4'd3,  1'b0, 1'b1, V_SUB};
    vecs[4]  = '{"jmp",        4'd4,  1'b1, 1'b1, V_JUMP};
    vecs[5]  = '{"jge_n1",     4'd5,  1'b1, 1'b0, V_QUIET};
    vecs[6]  = '{"jge_n0",     4'd5,  1'b0, 1'b1, V_JUMP};
    vecs[7]  = '{"jne_z1",     4'd6,  1'b0, 1'b1, V_QUIET};
    vecs[8]  = '{"jne_z0",     4'd6,  1'b1, 1'b0, V_JUMP};
    vecs[9]  = '{"rsv_8",      4'd8,  1'b0, 1'b0, V_QUIET};
    vecs[10] = '{"rsv_15",     4'd15, 1'b1, 1'b1, V_QUIET};
    vecs[11] = '{"jge_n1_z1",  4'd5,  1'b1, 1'b1, V_QUIET};

    Reset = 1'b0;
    F = 4'd0;
    N = 1'b0;
    Z = 1'b0;
    exp_count = 16'd0;

    #12;
    check("reset_outs", {5'd0, outs}, {5'd0, V_QUIET});
    check("reset_count", InstCount, 16'd0);
    @(negedge Clk);
    Reset = 1'b1;
    #1;

    // Decode table: FETCH, then EXECUTE of each vector, then counter update
    for (int i = 0; i < 12; i++) begin
      check({vecs[i].name, "_fetch"}, {5'd0, outs}, {5'd0, V_FETCH});
      F = vecs[i].f;
      N = vecs[i].n;
      Z = vecs[i].z;
      @(posedge Clk);
      @(negedge Clk);
      check({vecs[i].name, "_exec"}, {5'd0, outs}, {5'd0, vecs[i].exp});
      check({vecs[i].name, "_count_exec"}, InstCount, exp_count);
      @(posedge Clk);
      @(negedge Clk);
      exp_count = exp_count + 16'd1;
      check({vecs[i].name, "_count"}, InstCount, exp_count);
    end

    // Async reset in the middle of an ADD execute cycle
    F = 4'd2;
    @(posedge Clk);
    @(negedge Clk);
    check("abort_add_exec", {5'd0, outs}, {5'd0, V_ADD});
    #2 Reset = 1'b0;
    #1;
    check("abort_acc_en", {15'd0, Acc_En}, 16'd0);
    check("abort_memrq", {15'd0, MEMrq}, 16'd0);
    check("abort_count", InstCount, 16'd0);
    Reset = 1'b1;
    #1;
    check("abort_fetch", {5'd0, outs}, {5'd0, V_FETCH});
    check("abort_count_held", InstCount, 16'd0);
    F = 4'd9;
    @(posedge Clk);
    @(negedge Clk);
    @(posedge Clk);
    @(negedge Clk);
    exp_count = 16'd1;
    check("abort_restart_count", InstCount, exp_count);

    // STP then HALT
    F = 4'd7;
    @(posedge Clk);
    @(negedge Clk);
    check("stp_exec", {5'd0, outs}, {5'd0, V_QUIET});
    @(posedge Clk);
    @(negedge Clk);
    exp_count = exp_count + 16'd1;
    check("halt_outs", {5'd0, outs}, {5'd0, V_HALT});
    check("halt_count", InstCount, exp_count);
    F = 4'd0;
    N = 1'b1;
    Z = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge Clk);
      @(negedge Clk);
      check("halt_hold_outs", {5'd0, outs}, {5'd0, V_HALT});
      check("halt_hold_count", InstCount, exp_count);
    end
    #2 Reset = 1'b0;
    #1;
    check("halt_reset_count", InstCount, 16'd0);
    check("halt_reset_outs", {5'd0, outs}, {5'd0, V_QUIET});
    Reset = 1'b1;
    #1;
    check("halt_reset_fetch", {5'd0, outs}, {5'd0, V_FETCH});

    // InstCount wrap-around via reserved opcodes
    @(negedge Clk);
    Reset = 1'b0;
    #1 Reset = 1'b1;
    F = 4'hA;
    N = 1'b0;
    Z = 1'b0;
    for (int k = 0; k < 65535; k++) begin
      @(posedge Clk);
      @(posedge Clk);
    end
    @(negedge Clk);
    check("wrap_ffff", InstCount, 16'hFFFF);
    @(posedge Clk);
    @(negedge Clk);
    check("wrap_exec_hold", InstCount, 16'hFFFF);
    @(posedge Clk);
    @(negedge Clk);
    check("wrap_zero", InstCount, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mu0_control.md
MU0_CONTROL -- requirements
Module: mu0_control

Interface
REQ-001 SHALL have port Clk  input  1  single system clock; all state updates on rising edge.
REQ-002 SHALL have port Reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-003 SHALL have port F  input  4  opcode field, IR[15:12].
REQ-004 SHALL have port N  input  1  negative flag from mu0_flags (Acc[15]).
REQ-005 SHALL have port Z  input  1  zero flag from mu0_flags (Acc == 0).
REQ-006 SHALL have ports X_sel, Y_sel, Addr_sel  output  1 each  datapath mux selects.
- X_sel: 0 = Acc, 1 = PC.
- Y_sel: 0 = IR[11:0] zero-extended, 1 = memory data.
- Addr_sel: 0 = PC, 1 = IR[11:0].
REQ-007 SHALL have ports PC_En, IR_En, Acc_En  output  1 each  register load enables.
REQ-008 SHALL have port ALU_FS  output  2  ALU function: 00 = Y, 01 = X+Y, 10 = X+1, 11 = X-Y.
REQ-009 SHALL have ports MEMrq, RnW  output  1 each  memory request; 1 = read, 0 = write.
REQ-010 SHALL have port Halted  output  1  high while in HALT.
REQ-011 SHALL have port InstCount  output  16  count of executed instructions.

Function
REQ-012 SHALL implement three states: FETCH, EXECUTE, HALT.
- Transitions: FETCH->EXECUTE always; EXECUTE->FETCH, except F = 7 (STP) -> HALT; HALT->HALT until reset.
REQ-013 SHALL decode outputs combinationally from state, F, N and Z (Moore in FETCH/HALT, Mealy on F/N/Z in EXECUTE).
- Any enable, MEMrq or ALU_FS not listed for a case below is 0.
- X_sel, Y_sel, Addr_sel and RnW default to 0.
REQ-014 FETCH SHALL drive Addr_sel=0, MEMrq=1, RnW=1, IR_En=1, X_sel=1, ALU_FS=10, PC_En=1.
REQ-015 EXECUTE with F=0 (LDA) SHALL drive Addr_sel=1, MEMrq=1, RnW=1, Y_sel=1, ALU_FS=00, Acc_En=1.
REQ-016 EXECUTE with F=1 (STA) SHALL drive Addr_sel=1, MEMrq=1, RnW=0, with no enables.
REQ-017 EXECUTE with F=2 (ADD) or F=3 (SUB) SHALL drive:
- Addr_sel=1, MEMrq=1, RnW=1, X_sel=0, Y_sel=1, Acc_En=1.
- ALU_FS=01 for ADD, 11 for SUB.
REQ-018 EXECUTE with F=4 (JMP), 5 (JGE) or 6 (JNE) SHALL drive Y_sel=0, ALU_FS=00 and a conditional PC_En:
- JMP: PC_En=1.
- JGE: PC_En=~N.
- JNE: PC_En=~Z.
REQ-019 EXECUTE with F=7 (STP), or with F=8..15 (reserved, executed as no-op), SHALL assert no enables and MEMrq=0.
REQ-020 HALT SHALL hold all enables and MEMrq at 0 and hold Halted=1; Halted SHALL be 0 in all other states.
REQ-021 InstCount SHALL increment by 1 on the clock edge ending each EXECUTE cycle, including STP and reserved opcodes.
- Wraps 16'hFFFF -> 16'h0000.
- Never increments in FETCH or HALT.
REQ-022 N and Z SHALL be sampled in the EXECUTE cycle, i.e. they reflect Acc before any update in that cycle.

Reset
REQ-023 Reset=0 SHALL immediately, with no clock edge required, force state to FETCH and InstCount to 0.
REQ-024 Reset asserted mid-EXECUTE SHALL abandon the instruction; InstCount SHALL NOT increment for it.
REQ-025 After Reset deasserts, the first rising Clk edge SHALL complete a FETCH cycle.

Structure
REQ-026 Opcode values, state encodings and ALU_FS codes SHALL live in the shared package mu0_pkg, also used by the datapath and ALU.
REQ-027 A combinational sub-module mu0_decode SHALL map {state, F, N, Z} to the control outputs.
- The FSM and InstCount registers SHALL remain in mu0_control.

Verification
REQ-028 Bench SHALL apply reset, then F=0 -> FETCH outputs per REQ-014, then LDA outputs per REQ-015, then InstCount=1.
REQ-029 Bench SHALL execute JGE with N=1 -> PC_En=0; then JGE with N=0 -> PC_En=1, Y_sel=0, ALU_FS=00.
REQ-030 Bench SHALL execute JNE with Z=1 -> PC_En=0; then JNE with Z=0 -> PC_En=1.
REQ-031 Bench SHALL execute STP -> Halted=1 from the next edge; 10 further clocks -> outputs unchanged, InstCount frozen.
- Reset then -> FETCH, InstCount=0.
REQ-032 Bench SHALL force InstCount to 16'hFFFF (via 65535 reserved-opcode instructions) -> next EXECUTE edge gives 16'h0000.
REQ-033 Bench SHALL pulse Reset=0 asynchronously mid-EXECUTE of ADD -> Acc_En and MEMrq drop immediately; state FETCH; InstCount unchanged at 0.
